// File: rtl/sbqm_queue_ctrl.sv
// Purpose : SBqM queue controller. Sensor edges drive a saturating 0..7 person count,
//           which addresses the per-teller wait-time ROMs; the selected ROM word is latched as wtime.
// Latency : sensor -> pcount in 3 edges (+DEBOUNCE_CYCLES when filtered); pcount/tcount change -> wtime in 3 edges.
// Backpr. : none; every accepted sensor edge is applied at once. A new trigger restarts the lookup.
//
// Optional feature macro: SBQM_DEBOUNCE_EN (per-sensor debounce filter, DEBOUNCE_CYCLES samples).
//
// Ports:
//   clk, rst            : single clock, synchronous active-high reset
//   front_sensor        : entrance photocell (async), rising edge = arrival
//   back_sensor         : exit photocell (async), rising edge = departure
//   tcount[1:0]         : active tellers 1..3 (0 treated as 1)
//   wt_t1/wt_t2/wt_t3   : registered outputs of the 1/2/3-teller wait-time ROMs
//   rom_addr[2:0]       : shared ROM address, pcount-1 (0 when empty)
//   pcount[2:0]         : persons in queue; full = (pcount==7), empty = (pcount==0)
//   wtime[4:0]          : latched wait time in minutes
//   wtime_valid         : wtime matches the current pcount and tcount
module sbqm_queue_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       front_sensor,
  input  logic       back_sensor,
  input  logic [1:0] tcount,
  input  logic [4:0] wt_t1,
  input  logic [4:0] wt_t2,
  input  logic [4:0] wt_t3,
  output logic [2:0] rom_addr,
  output logic [2:0] pcount,
  output logic       full,
  output logic       empty,
  output logic [4:0] wtime,
  output logic       wtime_valid
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOOKUP  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  // Out-of-range settings elaborate this (empty) marker block so they show up in the hierarchy.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_debounce_cycles_out_of_range
  end

  // ---------------------------------------------------------------------------
  // Two-flop synchronizers
  // ---------------------------------------------------------------------------
  logic front_s1_q, front_s1_d, front_s2_q, front_s2_d;
  logic back_s1_q,  back_s1_d,  back_s2_q,  back_s2_d;

  always_comb begin
    front_s1_d = front_sensor;
    front_s2_d = front_s1_q;
    back_s1_d  = back_sensor;
    back_s2_d  = back_s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      front_s1_q <= 1'b0;
      front_s2_q <= 1'b0;
      back_s1_q  <= 1'b0;
      back_s2_q  <= 1'b0;
    end else begin
      front_s1_q <= front_s1_d;
      front_s2_q <= front_s2_d;
      back_s1_q  <= back_s1_d;
      back_s2_q  <= back_s2_d;
    end
  end

  // Level seen by the edge detectors: filtered or straight from the synchronizer.
  logic front_lvl;
  logic back_lvl;

`ifdef SBQM_DEBOUNCE_EN
  // The filtered level flips only on the DEBOUNCE_CYCLES-th consecutive sample that
  // disagrees with it; any agreeing sample clears the run counter.
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       front_filt_q, front_filt_d, back_filt_q, back_filt_d;
  logic [7:0] front_cnt_q,  front_cnt_d,  back_cnt_q,  back_cnt_d;

  always_comb begin
    front_filt_d = front_filt_q;
    front_cnt_d  = '0;
    if (front_s2_q != front_filt_q) begin
      if (front_cnt_q == DB_LAST) begin
        front_filt_d = front_s2_q;
      end else begin
        front_cnt_d = front_cnt_q + 8'd1;
      end
    end

    back_filt_d = back_filt_q;
    back_cnt_d  = '0;
    if (back_s2_q != back_filt_q) begin
      if (back_cnt_q == DB_LAST) begin
        back_filt_d = back_s2_q;
      end else begin
        back_cnt_d = back_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      front_filt_q <= 1'b0;
      front_cnt_q  <= '0;
      back_filt_q  <= 1'b0;
      back_cnt_q   <= '0;
    end else begin
      front_filt_q <= front_filt_d;
      front_cnt_q  <= front_cnt_d;
      back_filt_q  <= back_filt_d;
      back_cnt_q   <= back_cnt_d;
    end
  end

  assign front_lvl = front_filt_q;
  assign back_lvl  = back_filt_q;
`else
  assign front_lvl = front_s2_q;
  assign back_lvl  = back_s2_q;
`endif

  // ---------------------------------------------------------------------------
  // Rising-edge detectors: arr/dep are single-cycle pulses
  // ---------------------------------------------------------------------------
  logic front_prev_q, front_prev_d, back_prev_q, back_prev_d;
  logic arr, dep;

  always_comb begin
    front_prev_d = front_lvl;
    back_prev_d  = back_lvl;
    arr          = front_lvl & ~front_prev_q;
    dep          = back_lvl  & ~back_prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      front_prev_q <= 1'b0;
      back_prev_q  <= 1'b0;
    end else begin
      front_prev_q <= front_prev_d;
      back_prev_q  <= back_prev_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating person counter with registered full/empty flags
  // ---------------------------------------------------------------------------
  logic [2:0] pcount_q, pcount_d;
  logic       full_q, full_d, empty_q, empty_d;
  logic       pcount_chg;

  always_comb begin
    pcount_d = pcount_q;
    // Simultaneous arrival and departure cancel out.
    if (arr && !dep && pcount_q != 3'd7) begin
      pcount_d = pcount_q + 3'd1;
    end else if (dep && !arr && pcount_q != 3'd0) begin
      pcount_d = pcount_q - 3'd1;
    end
    pcount_chg = (pcount_d != pcount_q);
    full_d     = (pcount_d == 3'd7);
    empty_d    = (pcount_d == 3'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcount_q <= 3'd0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      pcount_q <= pcount_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // ROM entry is indexed by persons ahead of the newest arrival.
  assign rom_addr = (pcount_q == 3'd0) ? 3'd0 : (pcount_q - 3'd1);

  // ---------------------------------------------------------------------------
  // Teller count: normalized so that 0 and 1 are the same setting; a change of
  // the normalized value against the registered copy is a lookup trigger.
  // ---------------------------------------------------------------------------
  logic [1:0] tcount_n;
  logic [1:0] tcount_q, tcount_d;
  logic       tcount_chg;

  always_comb begin
    tcount_n   = (tcount == 2'd0) ? 2'd1 : tcount;
    tcount_d   = tcount_n;
    tcount_chg = (tcount_n != tcount_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tcount_q <= 2'd1;
    end else begin
      tcount_q <= tcount_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Lookup FSM: IDLE -> LOOKUP (ROMs register the address) -> CAPTURE (latch).
  // Any trigger while a lookup is in flight restarts it from LOOKUP.
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [4:0] wtime_q, wtime_d;
  logic       wtime_valid_q, wtime_valid_d;
  logic [4:0] wt_sel;
  logic       trigger;

  always_comb begin
    trigger = pcount_chg | tcount_chg;

    wt_sel = wt_t1;
    case (tcount_n)
      2'd2:    wt_sel = wt_t2;
      2'd3:    wt_sel = wt_t3;
      default: wt_sel = wt_t1;
    endcase
    // Empty queue means no wait, whatever the ROM holds.
    if (pcount_q == 3'd0) begin
      wt_sel = 5'd0;
    end
  end

  always_comb begin
    state_d       = state_q;
    wtime_d       = wtime_q;
    wtime_valid_d = wtime_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d       = ST_LOOKUP;
          wtime_valid_d = 1'b0;
        end
      end
      ST_LOOKUP: begin
        state_d       = trigger ? ST_LOOKUP : ST_CAPTURE;
        wtime_valid_d = 1'b0;
      end
      ST_CAPTURE: begin
        if (trigger) begin
          state_d       = ST_LOOKUP;
          wtime_valid_d = 1'b0;
        end else begin
          state_d       = ST_IDLE;
          wtime_d       = wt_sel;
          wtime_valid_d = 1'b1;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        wtime_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wtime_q       <= 5'd0;
      wtime_valid_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      wtime_q       <= wtime_d;
      wtime_valid_q <= wtime_valid_d;
    end
  end

  assign pcount      = pcount_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign wtime       = wtime_q;
  assign wtime_valid = wtime_valid_q;

endmodule

// File: tb/tb_sbqm_queue_ctrl.sv
// Bench for sbqm_queue_ctrl: external ROM model, table-driven vectors, timed corner
// sequences and random operations checked against a count/lookup reference model.
module tb_sbqm_queue_ctrl;

  localparam int DBC = 4;
`ifdef SBQM_DEBOUNCE_EN
  localparam int LAT = DBC;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       front_sensor = 1'b0;
  logic       back_sensor = 1'b0;
  logic [1:0] tcount = 2'd1;
  logic [4:0] wt_t1 = 5'd0;
  logic [4:0] wt_t2 = 5'd0;
  logic [4:0] wt_t3 = 5'd0;
  logic [2:0] rom_addr;
  logic [2:0] pcount;
  logic       full;
  logic       empty;
  logic [4:0] wtime;
  logic       wtime_valid;

  int n_chk  = 0;
  int n_pass = 0;

  sbqm_queue_ctrl #(.DEBOUNCE_CYCLES(DBC)) dut (
    .clk          (clk),
    .rst          (rst),
    .front_sensor (front_sensor),
    .back_sensor  (back_sensor),
    .tcount       (tcount),
    .wt_t1        (wt_t1),
    .wt_t2        (wt_t2),
    .wt_t3        (wt_t3),
    .rom_addr     (rom_addr),
    .pcount       (pcount),
    .full         (full),
    .empty        (empty),
    .wtime        (wtime),
    .wtime_valid  (wtime_valid)
  );

  always #5 clk = ~clk;

  // Wait-time ROM contents: one teller 3*(a+1), two tellers ceil-half of that, three tellers a+1.
  function automatic int rom_val(input int tellers, input int a);
    case (tellers)
      2:       return (3 * (a + 1) + 1) / 2;
      3:       return a + 1;
      default: return 3 * (a + 1);
    endcase
  endfunction

  // Registered ROMs, all addressed by rom_addr.
  always @(posedge clk) begin
    wt_t1 <= 5'(rom_val(1, int'(rom_addr)));
    wt_t2 <= 5'(rom_val(2, int'(rom_addr)));
    wt_t3 <= 5'(rom_val(3, int'(rom_addr)));
  end

  // Reference model.
  function automatic int model_next(input int p, input bit f, input bit b);
    if (f && !b && p < 7) return p + 1;
    if (b && !f && p > 0) return p - 1;
    return p;
  endfunction

  function automatic int exp_wtime(input int p, input int tc);
    int tn;
    tn = (tc == 0) ? 1 : tc;
    if (p == 0) return 0;
    return rom_val(tn, p - 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string nm, input int p, input int w);
    chk({nm, ".pcount"},   int'(pcount), p);
    chk({nm, ".full"},     int'(full), (p == 7) ? 1 : 0);
    chk({nm, ".empty"},    int'(empty), (p == 0) ? 1 : 0);
    chk({nm, ".rom_addr"}, int'(rom_addr), (p == 0) ? 0 : p - 1);
    chk({nm, ".wtime"},    int'(wtime), w);
    chk({nm, ".valid"},    int'(wtime_valid), 1);
  endtask

  task automatic do_op(input bit f, input bit b, input int tc);
    tcount       = 2'(tc);
    front_sensor = f;
    back_sensor  = b;
    repeat (LAT + 2) tick();
    front_sensor = 1'b0;
    back_sensor  = 1'b0;
    repeat (LAT + 10) tick();
  endtask

  typedef struct {
    bit f;
    bit b;
    int tc;
    int p;
    int w;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit f, input bit b, input int tc, input int p, input int w);
    vec_t v;
    v.f = f; v.b = b; v.tc = tc; v.p = p; v.w = w;
    vecs.push_back(v);
  endtask

  initial begin
    int m_p;
    int m_tc;

    // Expected results written out from the ROM contents above.
    // 9 arrivals with two tellers: saturates at 7.
    add(1, 0, 2, 1, 2);  add(1, 0, 2, 2, 3);  add(1, 0, 2, 3, 5);
    add(1, 0, 2, 4, 6);  add(1, 0, 2, 5, 8);  add(1, 0, 2, 6, 9);
    add(1, 0, 2, 7, 11); add(1, 0, 2, 7, 11); add(1, 0, 2, 7, 11);
    // 8 departures: bottoms out at 0.
    add(0, 1, 2, 6, 9);  add(0, 1, 2, 5, 8);  add(0, 1, 2, 4, 6);
    add(0, 1, 2, 3, 5);  add(0, 1, 2, 2, 3);  add(0, 1, 2, 1, 2);
    add(0, 1, 2, 0, 0);  add(0, 1, 2, 0, 0);
    // Refill to 4 with one teller, then both sensors together and teller changes.
    add(1, 0, 1, 1, 3);  add(1, 0, 1, 2, 6);  add(1, 0, 1, 3, 9);
    add(1, 0, 1, 4, 12); add(1, 1, 1, 4, 12); add(0, 0, 3, 4, 4);
    add(0, 0, 0, 4, 12); add(0, 0, 2, 4, 6);

    // Reset, then idle.
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    check_state("reset_idle", 0, 0);

    // Exact timing of one arrival with two tellers.
    tcount = 2'd2;
    repeat (6) tick();
    front_sensor = 1'b1;
    for (int i = 0; i <= LAT + 5; i++) begin
      tick();
      chk($sformatf("arr_timing%0d.pcount", i), int'(pcount), (i >= LAT + 2) ? 1 : 0);
      chk($sformatf("arr_timing%0d.valid", i), int'(wtime_valid),
          (i == LAT + 2 || i == LAT + 3) ? 0 : 1);
      chk($sformatf("arr_timing%0d.wtime", i), int'(wtime), (i >= LAT + 4) ? 2 : 0);
      if (i == LAT + 1) front_sensor = 1'b0;
    end

    // Reset on the edge a pending arrival would land, with a lookup in flight.
    front_sensor = 1'b1;
    for (int i = 0; i <= LAT + 1; i++) begin
      tick();
      if (i == LAT) begin
        front_sensor = 1'b0;
        tcount       = 2'd3;
      end
    end
    rst    = 1'b1;
    tcount = 2'd1;
    tick();
    rst = 1'b0;
    check_state("mid_reset", 0, 0);
    repeat (6) tick();
    check_state("post_reset", 0, 0);

    // Table-driven vectors.
    foreach (vecs[i]) begin
      do_op(vecs[i].f, vecs[i].b, vecs[i].tc);
      check_state($sformatf("vec%0d", i), vecs[i].p, vecs[i].w);
    end

    // Simultaneous arrival and departure at 4: no change, valid never drops.
    front_sensor = 1'b1;
    back_sensor  = 1'b1;
    for (int i = 0; i <= LAT + 7; i++) begin
      tick();
      chk($sformatf("both%0d.valid", i), int'(wtime_valid), 1);
      chk($sformatf("both%0d.pcount", i), int'(pcount), 4);
      if (i == LAT + 1) begin
        front_sensor = 1'b0;
        back_sensor  = 1'b0;
      end
    end

    // pcount 5, tcount 1 -> 3: wtime valid on the third edge.
    do_op(0, 0, 1);
    check_state("tc1_p4", 4, exp_wtime(4, 1));
    do_op(1, 0, 1);
    check_state("tc1_p5", 5, exp_wtime(5, 1));
    tcount = 2'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("tc_chg%0d.valid", i), int'(wtime_valid), (i < 2) ? 0 : 1);
    end
    chk("tc_chg.wtime", int'(wtime), exp_wtime(5, 3));

    // Arrival landing while the tcount lookup sits in LOOKUP restarts it.
    do_op(0, 0, 1);
    check_state("restart_pre", 5, exp_wtime(5, 1));
    front_sensor = 1'b1;
    for (int i = 0; i <= LAT + 4; i++) begin
      tick();
      if (i == LAT) tcount = 2'd3;
      if (i == LAT + 1) front_sensor = 1'b0;
      if (i == LAT + 1) chk("restart.valid_T", int'(wtime_valid), 0);
      if (i == LAT + 2) chk("restart.pcount", int'(pcount), 6);
      if (i == LAT + 2) chk("restart.valid_E", int'(wtime_valid), 0);
      if (i == LAT + 3) chk("restart.valid_E1", int'(wtime_valid), 0);
      if (i == LAT + 3) chk("restart.wtime_held", int'(wtime), exp_wtime(5, 1));
    end
    check_state("restart_final", 6, exp_wtime(6, 3));

    // Three-cycle glitch: filtered out only when debounce is enabled.
    front_sensor = 1'b1;
    repeat (3) tick();
    front_sensor = 1'b0;
    repeat (LAT + 10) tick();
`ifdef SBQM_DEBOUNCE_EN
    m_p = 6;
`else
    m_p = 7;
`endif
    m_tc = 3;
    check_state("glitch", m_p, exp_wtime(m_p, m_tc));

    // Random operations against the reference model.
    for (int n = 0; n < 150; n++) begin
      int  r;
      bit  f;
      bit  b;
      r = int'($urandom_range(99, 0));
      f = 1'b0;
      b = 1'b0;
      if (r < 40) f = 1'b1;
      else if (r < 75) b = 1'b1;
      else if (r < 85) begin f = 1'b1; b = 1'b1; end
      else m_tc = int'($urandom_range(3, 0));
      do_op(f, b, m_tc);
      m_p = model_next(m_p, f, b);
      chk($sformatf("rnd%0d.pcount", n), int'(pcount), m_p);
      chk($sformatf("rnd%0d.wtime", n), int'(wtime), exp_wtime(m_p, m_tc));
      chk($sformatf("rnd%0d.valid", n), int'(wtime_valid), 1);
      chk($sformatf("rnd%0d.full", n), int'(full), (m_p == 7) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
